// File: rtl/prg_upload.sv
// Streams the BASIC program from main RAM back to the HPS as a .PRG image.
// Define PRG_UPLOAD_HEADER_EN to prepend the 2-byte load-address header.
module prg_upload #(
    parameter logic [15:0] PTR_START = 16'h002B,
    parameter logic [15:0] PTR_END   = 16'h002D
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        upload_ready,
    output logic        upload_done,
    output logic [16:0] upload_len,
    output logic [15:0] ram_addr,
    output logic        ram_rd,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P0,
        S_P1,
        S_P2,
        S_P3,
`ifdef PRG_UPLOAD_HEADER_EN
        S_HDR0,
        S_HDR1,
`endif
        S_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_phase;
    logic        r_upl_d;
    logic [15:0] r_start;
    logic [7:0]  r_end_lo;
    logic [15:0] r_left;
    logic [7:0]  r_din;
    logic        r_ready;
    logic        r_done;
    logic [16:0] r_len;
    logic [15:0] r_addr;
    logic        r_rd;

    logic        w_rise;
    logic        w_consume;
    logic [15:0] w_end;
    logic [16:0] w_diff;
    logic [16:0] w_len;

    assign w_rise    = ioctl_upload & ~r_upl_d;
    assign w_consume = r_ready & ioctl_rd;
    assign w_end     = {ram_dout, r_end_lo};
    assign w_diff    = {1'b0, w_end} - {1'b0, r_start};
    // A borrow means end < start; programs never wrap, so clamp to empty.
    assign w_len     = w_diff[16] ? 17'd0 : w_diff;

    assign ioctl_din    = r_din;
    assign upload_ready = r_ready;
    assign upload_done  = r_done;
    assign upload_len   = r_len;
    assign ram_addr     = r_addr;
    assign ram_rd       = r_rd;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_phase  <= 2'd0;
            // Level already high at reset release must not count as an edge.
            r_upl_d  <= 1'b1;
            r_start  <= 16'd0;
            r_end_lo <= 8'd0;
            r_left   <= 16'd0;
            r_din    <= 8'd0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_len    <= 17'd0;
            r_addr   <= 16'd0;
            r_rd     <= 1'b0;
        end else begin
            r_upl_d <= ioctl_upload;
            if (r_state != S_IDLE && !ioctl_upload) begin
                r_state <= S_IDLE;
                r_phase <= 2'd0;
                r_din   <= 8'd0;
                r_ready <= 1'b0;
                r_done  <= 1'b0;
                r_len   <= 17'd0;
                r_addr  <= 16'd0;
                r_rd    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            r_state <= S_P0;
                            r_phase <= 2'd0;
                            r_rd    <= 1'b1;
                            r_addr  <= PTR_START;
                        end
                    end
                    S_P0: begin
                        if (!r_phase[0]) begin
                            r_rd    <= 1'b0;
                            r_phase <= 2'd1;
                        end else begin
                            r_start[7:0] <= ram_dout;
                            r_state      <= S_P1;
                            r_phase      <= 2'd0;
                            r_rd         <= 1'b1;
                            r_addr       <= PTR_START + 16'd1;
                        end
                    end
                    S_P1: begin
                        if (!r_phase[0]) begin
                            r_rd    <= 1'b0;
                            r_phase <= 2'd1;
                        end else begin
                            r_start[15:8] <= ram_dout;
                            r_state       <= S_P2;
                            r_phase       <= 2'd0;
                            r_rd          <= 1'b1;
                            r_addr        <= PTR_END;
                        end
                    end
                    S_P2: begin
                        if (!r_phase[0]) begin
                            r_rd    <= 1'b0;
                            r_phase <= 2'd1;
                        end else begin
                            r_end_lo <= ram_dout;
                            r_state  <= S_P3;
                            r_phase  <= 2'd0;
                            r_rd     <= 1'b1;
                            r_addr   <= PTR_END + 16'd1;
                        end
                    end
                    S_P3: begin
                        if (!r_phase[0]) begin
                            r_rd    <= 1'b0;
                            r_phase <= 2'd1;
                        end else begin
                            r_left  <= w_len[15:0];
                            r_addr  <= r_start;
                            r_phase <= 2'd0;
`ifdef PRG_UPLOAD_HEADER_EN
                            r_len   <= w_len + 17'd2;
                            r_state <= S_HDR0;
                            r_din   <= r_start[7:0];
                            r_ready <= 1'b1;
`else
                            r_len <= w_len;
                            if (w_len == 17'd0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                                r_rd    <= 1'b1;
                            end
`endif
                        end
                    end
`ifdef PRG_UPLOAD_HEADER_EN
                    S_HDR0: begin
                        if (w_consume) begin
                            r_ready <= 1'b0;
                            r_state <= S_HDR1;
                            r_phase <= 2'd0;
                        end
                    end
                    S_HDR1: begin
                        if (r_phase == 2'd0) begin
                            r_din   <= r_start[15:8];
                            r_ready <= 1'b1;
                            r_phase <= 2'd1;
                        end else if (w_consume) begin
                            r_ready <= 1'b0;
                            r_phase <= 2'd0;
                            if (r_left == 16'd0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                                r_rd    <= 1'b1;
                            end
                        end
                    end
`endif
                    S_DATA: begin
                        if (r_phase == 2'd0) begin
                            r_rd    <= 1'b0;
                            r_phase <= 2'd1;
                        end else if (r_phase == 2'd1) begin
                            r_din   <= ram_dout;
                            r_ready <= 1'b1;
                            r_phase <= 2'd2;
                        end else if (w_consume) begin
                            r_ready <= 1'b0;
                            r_addr  <= r_addr + 16'd1;
                            r_left  <= r_left - 16'd1;
                            r_phase <= 2'd0;
                            if (r_left == 16'd1) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_rd <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_ready <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prg_upload.sv
// Randomized bench for prg_upload against a queue-based .PRG reference.
// Follows PRG_UPLOAD_HEADER_EN the same way the design does.
module tb_prg_upload;

`ifdef PRG_UPLOAD_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        upload_ready;
    logic        upload_done;
    logic [16:0] upload_len;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_dout = 8'd0;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;

    prg_upload dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_din    (ioctl_din),
        .upload_ready (upload_ready),
        .upload_done  (upload_done),
        .upload_len   (upload_len),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_dout     (ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys)
        if (ram_rd) ram_dout <= mem[ram_addr];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_din"}, 64'(ioctl_din), 64'd0);
        check({tag, "_rdy"}, 64'(upload_ready), 64'd0);
        check({tag, "_done"}, 64'(upload_done), 64'd0);
        check({tag, "_len"}, 64'(upload_len), 64'd0);
        check({tag, "_addr"}, 64'(ram_addr), 64'd0);
        check({tag, "_rd"}, 64'(ram_rd), 64'd0);
    endtask

    // kind: 0 full upload, 1 drop level, 2 drop level with rd, 3 reset
    task automatic run(input logic [15:0] s, input logic [15:0] e,
                       input bit spam, input int kind);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int cyc, last, first, ndata, nrd, gap_exp, bad;
        bit fin, need_gap, prev_rdy, prev_cons, go;
        logic [7:0] prev_din;
        exp_q = {};
        got_q = {};
        if (HDR) begin
            exp_q.push_back(s[7:0]);
            exp_q.push_back(s[15:8]);
        end
        for (int a = int'(s); a < int'(e); a++) exp_q.push_back(mem[a]);
        mem[16'h002B] = s[7:0];
        mem[16'h002C] = s[15:8];
        mem[16'h002D] = e[7:0];
        mem[16'h002E] = e[15:8];
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        cyc = 0; last = -1; first = -1; nrd = 0; gap_exp = 0;
        fin = 0; need_gap = 0; prev_rdy = 0; prev_cons = 0; prev_din = 0;
        while (!fin && cyc < 3000) begin
            @(negedge clk_sys);
            cyc++;
            ioctl_rd = 1'b0;
            if (ram_rd) nrd++;
            ndata = got_q.size() - (HDR ? 2 : 0);
            if (upload_ready && first < 0) begin
                first = cyc;
                check("first_rdy", 64'(cyc), HDR ? 64'd9 : 64'd11);
            end
            if (upload_ready && need_gap) begin
                check("rdy_gap", 64'(cyc - last), 64'(gap_exp));
                need_gap = 0;
            end
            if (upload_ready && prev_rdy && !prev_cons)
                check("din_hold", 64'(ioctl_din), 64'(prev_din));
            prev_rdy  = upload_ready;
            prev_din  = ioctl_din;
            prev_cons = 0;
            if (upload_done) begin
                fin = 1;
                if (kind != 0)
                    check("early_done", 64'd1, 64'd0);
                else if (exp_q.size() == 0)
                    check("done_at", 64'(cyc), 64'd9);
                else
                    check("done_lat", 64'(cyc - last), 64'd1);
            end else if (kind != 0 && ndata >= 2) begin
                if (kind == 1) begin
                    ioctl_upload = 1'b0;
                    fin = 1;
                end else if (kind == 2 && upload_ready) begin
                    ioctl_upload = 1'b0;
                    ioctl_rd     = 1'b1;
                    fin = 1;
                end else if (kind == 3) begin
                    #2 reset = 1'b1;
                    #1 check_idle("async_rst");
                    fin = 1;
                end
            end else begin
                if (upload_ready) go = ($urandom_range(0, 2) != 0);
                else go = spam && ($urandom_range(0, 1) != 0);
                if (go) begin
                    ioctl_rd = 1'b1;
                    if (upload_ready) begin
                        got_q.push_back(ioctl_din);
                        last      = cyc;
                        prev_cons = 1;
                        need_gap  = got_q.size() < exp_q.size();
                        gap_exp   = (HDR && got_q.size() == 1) ? 2 : 3;
                    end
                end
            end
        end
        check("timeout", 64'(fin), 64'd1);
        if (kind == 1 || kind == 2) begin
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
            check_idle("abort");
            bad = 0;
            repeat (4) begin
                @(negedge clk_sys);
                if (ram_rd) bad++;
            end
            check("rd_after_abort", 64'(bad), 64'd0);
        end else if (kind == 3) begin
            @(negedge clk_sys);
            reset = 1'b0;
            bad = 0;
            repeat (10) begin
                @(negedge clk_sys);
                if (ram_rd || upload_ready || upload_done) bad++;
            end
            check("idle_after_rst", 64'(bad), 64'd0);
            ioctl_upload = 1'b0;
        end else begin
            check("upload_len", 64'(upload_len), 64'(exp_q.size()));
            check("nbytes", 64'(got_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                if (got_q[i] !== exp_q[i])
                    check($sformatf("byte%0d", i), 64'(got_q[i]),
                          64'(exp_q[i]));
            check("nreads", 64'(nrd), 64'(4 + exp_q.size() - (HDR ? 2 : 0)));
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
            check("done_hold", 64'(upload_done), 64'd1);
            ioctl_upload = 1'b0;
            @(negedge clk_sys);
            check("done_clr", 64'(upload_done), 64'd0);
            check("rdy_clr", 64'(upload_ready), 64'd0);
        end
    endtask

    initial begin
        logic [15:0] s;
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1001] = 8'hAA;
        mem[16'h1002] = 8'hBB;
        mem[16'h1003] = 8'hCC;
        repeat (3) @(negedge clk_sys);
        check_idle("reset");
        reset = 1'b0;
        run(16'h1001, 16'h1004, 1'b0, 0);
        run(16'h1001, 16'h1001, 1'b0, 0);
        run(16'h2000, 16'h1000, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            s = 16'($urandom_range(16'h0100, 16'hF000));
            run(s, s + 16'($urandom_range(1, 40)), 1'b1, 0);
        end
        run(16'hFFF0, 16'hFFFF, 1'b1, 0);
        run(16'h1001, 16'h1010, 1'b0, 1);
        run(16'h1001, 16'h1004, 1'b0, 0);
        run(16'h3000, 16'h3010, 1'b1, 2);
        run(16'h3000, 16'h3008, 1'b1, 0);
        run(16'h1001, 16'h1010, 1'b0, 3);
        run(16'h1001, 16'h1004, 1'b1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
